// File: rtl/rc4_pkg.sv
// Shared RC4 types: KSA state encoding, S-box size and the big-endian key byte picker.
package rc4_pkg;

    localparam int S_SIZE = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        WAIT_I,
        CAP_I,
        RD_J,
        WAIT_J,
        CAP_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

    // key[0] lives in the most significant byte of an nbytes-wide key, right-aligned in 64 bits
    function automatic byte_t key_byte_sel(input logic [63:0] key, input int nbytes, input int idx);
        return byte_t'(key >> ((nbytes - 1 - idx) * 8));
    endfunction

endpackage

// File: rtl/rc4_key_sched.sv
// Latched RC4 key plus a wrapping byte index; shared between the KSA and PRGA controllers.
module rc4_key_sched
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   advance,
    input  logic [KEY_BYTES*8-1:0] secret_key,
    output byte_t                  key_byte
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    logic [KEY_BYTES*8-1:0] key_reg;
    logic [KW-1:0]          kidx_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_reg  <= '0;
            kidx_reg <= '0;
        end else if (load) begin
            key_reg  <= secret_key;
            kidx_reg <= '0;
        end else if (advance) begin
            kidx_reg <= (kidx_reg == KW'(KEY_BYTES - 1)) ? '0 : kidx_reg + KW'(1);
        end
    end

    assign key_byte = key_byte_sel(64'(key_reg), KEY_BYTES, 32'(kidx_reg));

endmodule

// File: rtl/ksa_controller.sv
// RC4 key-scheduling sequencer: fills S with the identity, then runs the 256 read/read/write/write swaps.
module ksa_controller
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KEY_BYTES*8-1:0] secret_key,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_data,
    output logic                   mem_wren,
    output logic                   mem_rden,
    input  logic [7:0]             mem_q
);

    localparam byte_t LAST_IDX = byte_t'(S_SIZE - 1);

    ksa_state_t state_reg, state_next;
    byte_t      i_reg, i_next;
    byte_t      j_reg, j_next;
    byte_t      si_reg, si_next;
    byte_t      sj_reg, sj_next;
    logic [1:0] wait_reg, wait_next;
    byte_t      addr_reg, addr_next;
    byte_t      data_reg, data_next;
    logic       wren_reg, wren_next;
    logic       rden_reg, rden_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       key_load, key_advance;
    byte_t      key_byte;

    rc4_key_sched #(.KEY_BYTES(KEY_BYTES)) u_key_sched (
        .clk        (clk),
        .reset      (reset),
        .load       (key_load),
        .advance    (key_advance),
        .secret_key (secret_key),
        .key_byte   (key_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            si_reg    <= '0;
            sj_reg    <= '0;
            wait_reg  <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            wren_reg  <= 1'b0;
            rden_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            si_reg    <= si_next;
            sj_reg    <= sj_next;
            wait_reg  <= wait_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            wren_reg  <= wren_next;
            rden_reg  <= rden_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // Memory controls are computed from the current state and registered, so the port lags state by one cycle
    always_comb begin
        state_next  = state_reg;
        i_next      = i_reg;
        j_next      = j_reg;
        si_next     = si_reg;
        sj_next     = sj_reg;
        wait_next   = '0;
        addr_next   = addr_reg;
        data_next   = data_reg;
        wren_next   = 1'b0;
        rden_next   = 1'b0;
        done_next   = 1'b0;
        key_load    = 1'b0;
        key_advance = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    key_load   = 1'b1;
                    i_next     = '0;
                    j_next     = '0;
                    state_next = INIT;
                end
            end
            INIT: begin
                wren_next = 1'b1;
                addr_next = i_reg;
                data_next = i_reg;
                i_next    = i_reg + 8'd1;
                if (i_reg == LAST_IDX) state_next = RD_I;
            end
            RD_I: begin
                rden_next  = 1'b1;
                addr_next  = i_reg;
                state_next = (RD_LAT > 1) ? WAIT_I : CAP_I;
            end
            WAIT_I: begin
                wait_next = wait_reg + 2'd1;
                if (wait_reg == 2'(RD_LAT - 2)) state_next = CAP_I;
            end
            CAP_I: begin
                si_next    = mem_q;
                j_next     = j_reg + mem_q + key_byte;
                state_next = RD_J;
            end
            RD_J: begin
                rden_next  = 1'b1;
                addr_next  = j_reg;
                state_next = (RD_LAT > 1) ? WAIT_J : CAP_J;
            end
            WAIT_J: begin
                wait_next = wait_reg + 2'd1;
                if (wait_reg == 2'(RD_LAT - 2)) state_next = CAP_J;
            end
            CAP_J: begin
                sj_next    = mem_q;
                state_next = WR_I;
            end
            WR_I: begin
                wren_next  = 1'b1;
                addr_next  = i_reg;
                data_next  = sj_reg;
                state_next = WR_J;
            end
            WR_J: begin
                // When i==j both writes carry values captured before either write, so S[i] is unchanged
                wren_next = 1'b1;
                addr_next = j_reg;
                data_next = si_reg;
                if (i_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    i_next      = i_reg + 8'd1;
                    key_advance = 1'b1;
                    state_next  = RD_I;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign mem_addr = addr_reg;
    assign mem_data = data_reg;
    assign mem_wren = wren_reg;
    assign mem_rden = rden_reg;

endmodule

// File: tb/tb_ksa_controller.sv
// Scoreboard bench for ksa_controller: expected S-memory write streams are queued per run and popped by monitors.
module tb_ksa_controller;
    import rc4_pkg::*;

    localparam int KB_A = 3, LAT_A = 2;
    localparam int KB_B = 5, LAT_B = 3;
    localparam byte_t POISON = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b;
    logic [KB_A*8-1:0] key_a;
    logic [KB_B*8-1:0] key_b;
    logic busy_a, done_a, wren_a, rden_a;
    logic busy_b, done_b, wren_b, rden_b;
    logic [7:0] addr_a, data_a, q_a, addr_b, data_b, q_b;

    ksa_controller #(.KEY_BYTES(KB_A), .RD_LAT(LAT_A)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .secret_key(key_a),
        .busy(busy_a), .done(done_a), .mem_addr(addr_a), .mem_data(data_a),
        .mem_wren(wren_a), .mem_rden(rden_a), .mem_q(q_a)
    );

    ksa_controller #(.KEY_BYTES(KB_B), .RD_LAT(LAT_B)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .secret_key(key_b),
        .busy(busy_b), .done(done_b), .mem_addr(addr_b), .mem_data(data_b),
        .mem_wren(wren_b), .mem_rden(rden_b), .mem_q(q_b)
    );

    // Behavioural RAMs: read data is valid only in the single cycle RD_LAT edges after the address was registered
    byte_t ram_a [S_SIZE];
    byte_t ram_b [S_SIZE];
    byte_t st_a;
    logic  vl_a;
    byte_t st_b [2];
    logic [1:0] vl_b;

    always @(posedge clk) begin
        if (wren_a) ram_a[addr_a] <= data_a;
        st_a <= ram_a[addr_a];
        vl_a <= rden_a;
        if (wren_b) ram_b[addr_b] <= data_b;
        st_b[0] <= ram_b[addr_b];
        st_b[1] <= st_b[0];
        vl_b    <= {vl_b[0], rden_b};
    end
    assign q_a = vl_a ? st_a : POISON;
    assign q_b = vl_b[1] ? st_b[1] : POISON;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic [15:0] exp_a[$], exp_b[$];
    byte_t model_s [S_SIZE];
    int unsigned wcount_a, wcount_b, done_cnt_a = 0, done_cnt_b = 0, done_cyc_a, done_cyc_b;
    logic [15:0] wlog_a [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Textbook KSA; the expected port traffic is 256 identity writes then (i,S[j]),(j,S[i]) per iteration
    task automatic build_expect(input logic [63:0] key, input int kb, input bit for_b);
        byte_t s [S_SIZE];
        byte_t j, t, kbyte;
        for (int n = 0; n < S_SIZE; n++) begin
            s[n] = byte_t'(n);
            if (for_b) exp_b.push_back({byte_t'(n), byte_t'(n)});
            else       exp_a.push_back({byte_t'(n), byte_t'(n)});
        end
        j = 8'd0;
        for (int n = 0; n < S_SIZE; n++) begin
            kbyte = byte_t'(key >> ((kb - 1 - (n % kb)) * 8));
            j = j + s[n] + kbyte;
            if (for_b) begin
                exp_b.push_back({byte_t'(n), s[j]});
                exp_b.push_back({j, s[n]});
            end else begin
                exp_a.push_back({byte_t'(n), s[j]});
                exp_a.push_back({j, s[n]});
            end
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        model_s = s;
    endtask

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (wren_a || rden_a) chk("proto_a_rw_overlap", {31'd0, wren_a & rden_a}, 32'd0);
            if (wren_b || rden_b) chk("proto_b_rw_overlap", {31'd0, wren_b & rden_b}, 32'd0);
            if (wren_a) begin
                if (exp_a.size() == 0) chk("a_unexpected_write", {16'd0, addr_a, data_a}, 32'hFFFFFFFF);
                else chk($sformatf("a_write%0d", wcount_a), {16'd0, addr_a, data_a}, {16'd0, exp_a.pop_front()});
                if (wcount_a >= 256 && wcount_a < 260) wlog_a[wcount_a - 256] = {addr_a, data_a};
                wcount_a++;
            end
            if (wren_b) begin
                if (exp_b.size() == 0) chk("b_unexpected_write", {16'd0, addr_b, data_b}, 32'hFFFFFFFF);
                else chk($sformatf("b_write%0d", wcount_b), {16'd0, addr_b, data_b}, {16'd0, exp_b.pop_front()});
                wcount_b++;
            end
            if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
            if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
        end
    end

    task automatic run_a(input logic [23:0] key, input int hold, input bit disturb, input string tag);
        int unsigned t0, d0, k;
        int mism;
        exp_a.delete();
        build_expect(64'(key), KB_A, 1'b0);
        wcount_a = 0;
        d0 = done_cnt_a;
        @(negedge clk);
        key_a = key; start_a = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start_a = (hold > 1);
        while (done_cnt_a == d0 && (cyc - t0) < 3000) begin
            @(posedge clk); #1;
            k = cyc - t0;
            start_a = (k + 1 < hold) || (disturb && k == 1000);
            if (disturb && k == 1200) key_a = ~key;
            if (k == 1) chk({tag, "_busy_c1"}, {31'd0, busy_a}, 32'd1);
        end
        chk({tag, "_done_cycle"}, done_cyc_a - t0, 32'd2305);
        chk({tag, "_busy_after"}, {31'd0, busy_a}, 32'd0);
        repeat (20) begin @(posedge clk); #1; end
        chk({tag, "_done_pulses"}, done_cnt_a - d0, 32'd1);
        chk({tag, "_left_in_queue"}, exp_a.size(), 32'd0);
        mism = 0;
        for (int n = 0; n < S_SIZE; n++) if (ram_a[n] !== model_s[n]) mism++;
        chk({tag, "_final_array"}, mism, 32'd0);
        $display("run %s key=%06h writes=%0d done_at=%0d", tag, key, wcount_a, done_cyc_a - t0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned t0, d0;
        int mism;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; key_a = '0; key_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a_outputs", {10'd0, busy_a, done_a, wren_a, rden_a, addr_a, data_a}, 32'd0);
        chk("reset_b_outputs", {10'd0, busy_b, done_b, wren_b, rden_b, addr_b, data_b}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_a(24'h000000, 1, 1'b0, "key0");
        chk("key0_it0_wr_i", {16'd0, wlog_a[0]}, 32'h0000);
        chk("key0_it0_wr_j", {16'd0, wlog_a[1]}, 32'h0000);

        run_a(24'h010203, 1, 1'b0, "key010203");
        chk("k123_it0_wr_i", {16'd0, wlog_a[0]}, 32'h0001);
        chk("k123_it0_wr_j", {16'd0, wlog_a[1]}, 32'h0100);
        chk("k123_it1_wr_i", {16'd0, wlog_a[2]}, 32'h0103);
        chk("k123_it1_wr_j", {16'd0, wlog_a[3]}, 32'h0300);

        run_a(24'h5A17C3, 10, 1'b1, "disturb");

        // Abort during WR_I of iteration 100: only init plus 100 full swaps may reach the memory
        exp_a.delete();
        build_expect(64'(24'hBEEF01), KB_A, 1'b0);
        while (exp_a.size() > 456) void'(exp_a.pop_back());
        wcount_a = 0;
        @(negedge clk);
        key_a = 24'hBEEF01; start_a = 1'b1;
        @(posedge clk); #1;
        t0 = cyc; start_a = 1'b0;
        while ((cyc - t0) < 1062) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_wren", {31'd0, wren_a}, 32'd0);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_rden_done", {30'd0, rden_a, done_a}, 32'd0);
        reset = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("abort_stays_idle", {29'd0, busy_a, wren_a, rden_a}, 32'd0);
        chk("abort_write_count", wcount_a, 32'd456);
        $display("run abort key=beef01 writes=%0d", wcount_a);
        run_a(24'hBEEF01, 1, 1'b0, "rerun");

        // Wider key and longer read latency on the second instance
        exp_b.delete();
        build_expect(64'(40'h0102030405), KB_B, 1'b1);
        wcount_b = 0;
        d0 = done_cnt_b;
        @(negedge clk);
        key_b = 40'h0102030405; start_b = 1'b1;
        @(posedge clk); #1;
        t0 = cyc; start_b = 1'b0;
        while (done_cnt_b == d0 && (cyc - t0) < 3500) begin @(posedge clk); #1; end
        chk("lat3_done_cycle", done_cyc_b - t0, 32'd2817);
        repeat (20) begin @(posedge clk); #1; end
        chk("lat3_done_pulses", done_cnt_b - d0, 32'd1);
        chk("lat3_left_in_queue", exp_b.size(), 32'd0);
        mism = 0;
        for (int n = 0; n < S_SIZE; n++) if (ram_b[n] !== model_s[n]) mism++;
        chk("lat3_final_array", mism, 32'd0);
        $display("run lat3 key=0102030405 writes=%0d done_at=%0d", wcount_b, done_cyc_b - t0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ksa_controller.md
Name: ksa_controller

Overview:
- Sequences the full RC4 key-scheduling algorithm (KSA) against the 256x8 single-port S memory (s_memory).
- Phase 1 initialises S[i]=i.
- Phase 2 runs the 256-iteration shuffle j=j+S[i]+key[i mod KEY_BYTES], then swaps S[i] and S[j].
- Sole master of the S-memory port while busy. A downstream PRGA/decrypt block starts after done.

Parameters:
- KEY_BYTES, 3: secret key length in bytes (1..8).
- RD_LAT, 2: rising edges from the edge that registers mem_addr/mem_rden to the edge where mem_q is sampled (1..3).

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high
- start  in  1  request a run; sampled only in IDLE
- secret_key  in  KEY_BYTES*8  key; key[0] = bits [KEY_BYTES*8-1 -: 8] (big-endian)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the last swap write completes
- mem_addr  out  8  S-memory address (registered)
- mem_data  out  8  S-memory write data (registered)
- mem_wren  out  1  write enable (registered)
- mem_rden  out  1  read enable (registered)
- mem_q  in  8  S-memory read data

Behaviour:
- Reset values: busy=0, done=0, mem_wren=0, mem_rden=0, mem_addr=0, mem_data=0, i=0, j=0, state=IDLE. Reset overrides everything, including mid-run. No partial swap completes after reset.
- States: IDLE, INIT, RD_I, WAIT_I, CAP_I, RD_J, WAIT_J, CAP_J, WR_I, WR_J, DONE.
- IDLE: when start=1, latch secret_key into key_q, set i=0 and j=0, go to INIT. A start pulse held for several cycles starts exactly one run. start is ignored outside IDLE. secret_key changes after latch have no effect.
- INIT: on each cycle, mem_wren=1, mem_addr=i, mem_data=i, i++. After the write at i=255, i wraps to 0 and the state goes to RD_I. Produces exactly 256 consecutive write cycles.
- RD_I: mem_addr=i, mem_rden=1, mem_wren=0.
- WAIT_I: dwell RD_LAT-1 cycles (state skipped when RD_LAT=1).
- CAP_I: si_q<=mem_q; j<=j+mem_q+key_q[kidx], all mod 256 (8-bit wrap).
- RD_J / WAIT_J: same as RD_I / WAIT_I, using address j.
- CAP_J: sj_q<=mem_q.
- WR_I: mem_wren=1, addr=i, data=sj_q.
- WR_J: mem_wren=1, addr=j, data=si_q.
  - If i==255, go to DONE.
  - Otherwise i++, kidx advances mod KEY_BYTES, go to RD_I.
- Case i==j: both writes carry the same captured value, so S is unchanged. Captured values are used; there is no re-read.
- DONE: done=1 for one cycle, busy=0, mem_wren=0, return to IDLE.
- mem_rden=0 in every state except RD_I/RD_J. mem_wren=0 in every state except INIT/WR_I/WR_J.
- Timing: start sampled at edge 0. INIT writes occupy cycles 1..256. Each shuffle iteration takes 6+2*(RD_LAT-1) cycles, i.e. 8 at default. done is high in cycle 256+256*8+1 = 2305.
- kidx is a counter (0..KEY_BYTES-1, resets to 0 at run start); no modulo divider.

Decomposition:
- Package rc4_pkg holds:
  - ksa_state_t enum;
  - S_SIZE=256;
  - typedef byte_t (logic [7:0]);
  - key byte-select function.
- Sub-module rc4_key_sched: key_q register plus kidx counter. Interface: load, advance, key_byte. Reused later by the PRGA controller.

Test Plan:
- Reset, then 1-cycle start with key 24'h000000 → cycles 1..256 show mem_wren=1 with addr=data=0..255. Iteration 0 has j=0 (i==j) and writes addr 0 data 0 twice. done pulses exactly at cycle 2305. Final memory equals the C-model KSA.
- Key 24'h010203 on a behavioural RAM:
  - Iteration 0: j=1, writes S[0]=1 and S[1]=0.
  - Iteration 1: j=3, writes S[1]=3 and S[3]=0.
  - Full run matches the C-model array byte for byte.
- start held high 10 cycles, re-pulsed mid-shuffle, secret_key changed mid-shuffle → single run; final array matches the originally latched key; one done pulse only.
- reset asserted during WR_I of iteration 100 → next cycle mem_wren=0, busy=0, state IDLE. A following start re-runs INIT from address 0, and the final array matches the model.
- Build with RD_LAT=3 and KEY_BYTES=5, key 40'h0102030405 → each iteration takes 10 cycles; done at cycle 256+2560+1=2817; array matches the model.
- Protocol monitor through all runs: mem_rden and mem_wren never high together; mem_q sampled exactly RD_LAT edges after its address was registered.
